// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue sequencer: in-order micro-op queue feeding the ALU with
// registered operands, multi-cycle IMUL hold, branch bubble and redirect flush.
module alu_issue_ctrl #(
  parameter int DEPTH   = 2,
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_opcode,
  input  logic [63:0] in_oprd1,
  input  logic [63:0] in_oprd2,
  input  logic [63:0] in_oprd3,
  input  logic [63:0] in_next_rip,
  output logic        alu_enable,
  output logic [9:0]  alu_opcode,
  output logic [63:0] alu_oprd1,
  output logic [63:0] alu_oprd2,
  output logic [63:0] alu_oprd3,
  output logic [63:0] alu_next_rip,
  input  logic        mem_blocked,
  input  logic        branch,
  output logic        flush,
  output logic        busy,
  output logic [31:0] issued_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int MW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, MUL, BR_WAIT} state_t;

  // Handshake: a micro-op transfers on any edge where in_valid && in_ready.
  state_t        state, state_d;
  logic [MW-1:0] mcnt, mcnt_d;
  logic          en_d, flush_d, pop, clear, push, try_issue;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [9:0]  q_op  [DEPTH];
  logic [63:0] q_a   [DEPTH];
  logic [63:0] q_b   [DEPTH];
  logic [63:0] q_c   [DEPTH];
  logic [63:0] q_rip [DEPTH];

  logic [9:0] head_op;
  logic       head_mul, head_br;

  assign head_op  = q_op[head];
  assign head_mul = (head_op == 10'h0F7) || (head_op == 10'h1AF);
  assign head_br  = (head_op[9:4] == 6'b00_0111) || (head_op == 10'h0E9) ||
                    (head_op == 10'h0EB) || (head_op[9:4] == 6'b01_1000);

  assign in_ready = (count < CW'(DEPTH)) && (state != BR_WAIT);
  assign push     = in_valid && in_ready;
  assign busy     = (count != '0) || (state != IDLE);

  always_comb begin
    state_d   = state;
    mcnt_d    = mcnt;
    en_d      = alu_enable;
    flush_d   = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    try_issue = 1'b0;
    if (!mem_blocked) begin
      case (state)
        IDLE, ISSUE: try_issue = 1'b1;
        MUL: begin
          if (mcnt == MW'(1)) begin
            mcnt_d  = '0;
            en_d    = 1'b1;
            state_d = ISSUE;
          end else begin
            mcnt_d = mcnt - MW'(1);
            en_d   = 1'b0;
          end
        end
        BR_WAIT: begin
          // First cycle is the branch op's own enable; the second is the bubble
          // in which the ALU reports its redirect decision.
          if (alu_enable) begin
            en_d = 1'b0;
          end else if (branch) begin
            clear   = 1'b1;
            flush_d = 1'b1;
            en_d    = 1'b0;
            state_d = IDLE;
          end else begin
            try_issue = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (try_issue) begin
      if (count != '0) begin
        pop = 1'b1;
        if (head_mul && (MUL_LAT > 1)) begin
          state_d = MUL;
          mcnt_d  = MW'(MUL_LAT - 1);
          en_d    = 1'b0;
        end else if (head_br) begin
          en_d    = 1'b1;
          state_d = BR_WAIT;
        end else begin
          en_d    = 1'b1;
          state_d = ISSUE;
        end
      end else begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mcnt         <= '0;
      alu_enable   <= 1'b0;
      flush        <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      issued_cnt   <= '0;
      alu_opcode   <= '0;
      alu_oprd1    <= '0;
      alu_oprd2    <= '0;
      alu_oprd3    <= '0;
      alu_next_rip <= '0;
    end else begin
      state      <= state_d;
      mcnt       <= mcnt_d;
      alu_enable <= en_d;
      flush      <= flush_d;
      if (alu_enable && !mem_blocked) issued_cnt <= issued_cnt + 32'd1;
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      if (pop) begin
        alu_opcode   <= head_op;
        alu_oprd1    <= q_a[head];
        alu_oprd2    <= q_b[head];
        alu_oprd3    <= q_c[head];
        alu_next_rip <= q_rip[head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_op[tail]  <= in_opcode;
      q_a[tail]   <= in_oprd1;
      q_b[tail]   <= in_oprd2;
      q_c[tail]   <= in_oprd3;
      q_rip[tail] <= in_next_rip;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl (DEPTH=2, MUL_LAT=3) with an issue-order
// scoreboard fed by the expected opcode sequence of each scenario.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_opcode;
  logic [63:0] in_oprd1, in_oprd2, in_oprd3, in_next_rip;
  logic        alu_enable;
  logic [9:0]  alu_opcode;
  logic [63:0] alu_oprd1, alu_oprd2, alu_oprd3, alu_next_rip;
  logic        mem_blocked;
  logic        branch;
  logic        flush;
  logic        busy;
  logic [31:0] issued_cnt;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  alu_issue_ctrl #(.DEPTH(2), .MUL_LAT(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_oprd1(in_oprd1), .in_oprd2(in_oprd2), .in_oprd3(in_oprd3),
    .in_next_rip(in_next_rip),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode),
    .alu_oprd1(alu_oprd1), .alu_oprd2(alu_oprd2), .alu_oprd3(alu_oprd3),
    .alu_next_rip(alu_next_rip),
    .mem_blocked(mem_blocked), .branch(branch), .flush(flush),
    .busy(busy), .issued_cnt(issued_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_oprd1    = a;
    in_oprd2    = b;
    in_oprd3    = a ^ b;
    in_next_rip = {54'd0, op} + 64'h1000;
  endtask

  // scoreboard: every counted enable must match the next expected opcode
  always @(negedge clk) begin
    if (reset_n && alu_enable && !mem_blocked) begin
      if (exp_q.size() == 0) check("enable_without_expect", alu_enable, 0);
      else check("issue_order", alu_opcode, exp_q.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_opcode = '0;
    in_oprd1 = '0; in_oprd2 = '0; in_oprd3 = '0; in_next_rip = '0;
    mem_blocked = 1'b0; branch = 1'b0;
    step(); step();
    #2 reset_n = 1'b1;
    step();
    check("rst_enable", alu_enable, 0);
    check("rst_issued", issued_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_flush", flush, 0);
    check("rst_opcode", alu_opcode, 0);

    // single ADD
    exp_q.push_back(10'h001);
    offer(10'h001, 64'd5, 64'd7);
    step();
    in_valid = 1'b0;
    check("add_busy", busy, 1);
    check("add_early_en", alu_enable, 0);
    step();
    check("add_en", alu_enable, 1);
    check("add_op1", alu_oprd1, 5);
    check("add_op2", alu_oprd2, 7);
    check("add_op3", alu_oprd3, 2);
    check("add_rip", alu_next_rip, 64'h1001);
    step();
    check("add_en_off", alu_enable, 0);
    check("add_cnt", issued_cnt, 1);
    check("add_idle", busy, 0);

    // back-pressure with memory blocked
    exp_q.push_back(10'h002); exp_q.push_back(10'h003); exp_q.push_back(10'h004);
    mem_blocked = 1'b1;
    offer(10'h002, 64'd1, 64'd0);
    step();
    offer(10'h003, 64'd2, 64'd0);
    step();
    offer(10'h004, 64'd3, 64'd0);
    check("bp_full", in_ready, 0);
    step();
    check("bp_still_full", in_ready, 0);
    check("bp_frozen_en", alu_enable, 0);
    check("bp_frozen_cnt", issued_cnt, 1);
    mem_blocked = 1'b0;
    step();
    check("bp_en1", alu_enable, 1);
    check("bp_op1", alu_opcode, 10'h002);
    check("bp_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_op2", alu_opcode, 10'h003);
    check("bp_a2", alu_oprd1, 2);
    step();
    check("bp_op3", alu_opcode, 10'h004);
    check("bp_en3", alu_enable, 1);
    step();
    check("bp_done", alu_enable, 0);
    check("bp_cnt", issued_cnt, 4);

    // IMUL hold for three cycles, then the queued op
    exp_q.push_back(10'h1AF); exp_q.push_back(10'h005);
    offer(10'h1AF, 64'd3, 64'd4);
    step();
    offer(10'h005, 64'd9, 64'd1);
    step();
    in_valid = 1'b0;
    check("mul_c1_en", alu_enable, 0);
    check("mul_c1_op", alu_opcode, 10'h1AF);
    check("mul_c1_a", alu_oprd1, 3);
    check("mul_c1_b", alu_oprd2, 4);
    step();
    check("mul_c2_en", alu_enable, 0);
    check("mul_c2_a", alu_oprd1, 3);
    step();
    check("mul_c3_en", alu_enable, 1);
    check("mul_c3_b", alu_oprd2, 4);
    step();
    check("mul_next_en", alu_enable, 1);
    check("mul_next_op", alu_opcode, 10'h005);
    check("mul_next_a", alu_oprd1, 9);
    step();
    check("mul_cnt", issued_cnt, 6);

    // JMP with redirect flushes the queued op
    exp_q.push_back(10'h0E9);
    offer(10'h0E9, 64'd0, 64'd0);
    step();
    offer(10'h006, 64'd0, 64'd0);
    step();
    in_valid = 1'b0;
    check("jmp_en", alu_enable, 1);
    check("jmp_op", alu_opcode, 10'h0E9);
    check("jmp_ready_en", in_ready, 0);
    step();
    check("jmp_bubble_en", alu_enable, 0);
    check("jmp_bubble_ready", in_ready, 0);
    check("jmp_bubble_flush", flush, 0);
    branch = 1'b1;
    step();
    branch = 1'b0;
    check("jmp_flush", flush, 1);
    check("jmp_busy", busy, 0);
    check("jmp_ready_after", in_ready, 1);
    step();
    check("jmp_flush_pulse", flush, 0);
    check("jmp_no_issue", alu_enable, 0);
    step();
    check("jmp_cnt", issued_cnt, 7);

    // short Jcc, not taken: one bubble then the queued op
    exp_q.push_back(10'h074); exp_q.push_back(10'h007);
    offer(10'h074, 64'd0, 64'd0);
    step();
    offer(10'h007, 64'd8, 64'd0);
    step();
    in_valid = 1'b0;
    check("jcc_op", alu_opcode, 10'h074);
    check("jcc_ready", in_ready, 0);
    step();
    check("jcc_bubble", alu_enable, 0);
    step();
    check("jcc_next_en", alu_enable, 1);
    check("jcc_next_op", alu_opcode, 10'h007);
    check("jcc_no_flush", flush, 0);
    step();
    check("jcc_cnt", issued_cnt, 9);

    // redirect held across a memory stall is taken once unblocked
    exp_q.push_back(10'h0EB);
    offer(10'h0EB, 64'd0, 64'd0);
    step();
    in_valid = 1'b0;
    step();
    step();
    mem_blocked = 1'b1;
    branch = 1'b1;
    step();
    check("defer_flush", flush, 0);
    check("defer_busy", busy, 1);
    mem_blocked = 1'b0;
    step();
    branch = 1'b0;
    check("defer_flush_now", flush, 1);
    step();
    check("defer_cnt", issued_cnt, 10);

    // async reset in the middle of an IMUL
    offer(10'h0F7, 64'd6, 64'd7);
    step();
    in_valid = 1'b0;
    step();
    step();
    check("rmul_held", alu_opcode, 10'h0F7);
    #2 reset_n = 1'b0;
    #1;
    check("rmul_en", alu_enable, 0);
    check("rmul_cnt", issued_cnt, 0);
    check("rmul_busy", busy, 0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rmul_after_en", alu_enable, 0);
    check("rmul_after_busy", busy, 0);
    check("rmul_after_cnt", issued_cnt, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
